// File: rtl/aq_mmu_utlb_refill_ctrl.sv
// aq_mmu_utlb_refill_ctrl: sequences a single outstanding jTLB refill on a uTLB miss and pulses the victim entry update.
module aq_mmu_utlb_refill_ctrl #(
  parameter int ENTRY_NUM = 8,
  parameter int PTR_W     = 3
) (
  input  logic                 utlb_entry_clk,
  input  logic                 cpurst_b,
  input  logic                 utlb_lookup_req,
  input  logic [27:0]          utlb_req_vpn,
  input  logic [ENTRY_NUM-1:0] utlb_entry_hit_vec,
  input  logic [ENTRY_NUM-1:0] utlb_entry_vld_vec,
  input  logic                 cp0_mmu_satp_wen,
  input  logic                 tlboper_xx_clr,
  input  logic                 jtlb_utlb_grant,
  input  logic                 jtlb_utlb_done,
  input  logic                 jtlb_utlb_fault,
  output logic                 utlb_jtlb_req,
  output logic [27:0]          utlb_jtlb_vpn,
  output logic [ENTRY_NUM-1:0] utlb_entry_upd_vec,
  output logic                 utlb_miss_stall,
  output logic                 utlb_refill_fault
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, UPD, ABORT} state_t;
  localparam logic [ENTRY_NUM-1:0] ONE = 1;
  state_t state, state_nxt;
  logic [27:0] vpn_q;
  logic [PTR_W-1:0] rr_ptr, victim_q, inv_idx;
  logic miss, flush, any_inv, take_done;
  assign miss = utlb_lookup_req && !(|utlb_entry_hit_vec);
  assign flush = cp0_mmu_satp_wen || tlboper_xx_clr;
  assign any_inv = ~&utlb_entry_vld_vec;
  assign take_done = state == WAIT && jtlb_utlb_done && !flush;
  // lowest-index invalid entry wins: scan downward so the last hit is the lowest
  always_comb begin
    inv_idx = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--)
      if (!utlb_entry_vld_vec[i]) inv_idx = PTR_W'(i);
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = miss && !flush ? REQ : IDLE;
      REQ:   state_nxt = flush ? (jtlb_utlb_grant ? ABORT : IDLE) : (jtlb_utlb_grant ? WAIT : REQ);
      WAIT:  state_nxt = flush ? ((jtlb_utlb_done || jtlb_utlb_fault) ? IDLE : ABORT)
                               : jtlb_utlb_done ? UPD : jtlb_utlb_fault ? IDLE : WAIT;
      UPD:   state_nxt = IDLE;
      ABORT: state_nxt = (jtlb_utlb_done || jtlb_utlb_fault) ? IDLE : ABORT;
      default: state_nxt = IDLE;
    endcase
  end
  assign utlb_jtlb_req = state == REQ;
  assign utlb_jtlb_vpn = vpn_q;
  assign utlb_entry_upd_vec = state == UPD ? ONE << victim_q : '0;
  assign utlb_miss_stall = state != IDLE || miss;
  assign utlb_refill_fault = state == WAIT && jtlb_utlb_fault && !jtlb_utlb_done && !flush;
  always_ff @(posedge utlb_entry_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state    <= IDLE;
      vpn_q    <= '0;
      rr_ptr   <= '0;
      victim_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && miss && !flush) vpn_q <= utlb_req_vpn;
      if (take_done) victim_q <= any_inv ? inv_idx : rr_ptr;
      if (take_done && !any_inv) rr_ptr <= rr_ptr + 1'b1;
    end
  end
endmodule
